// File: rtl/alsu_if.sv
// alsu_if: operand/result bundle for the alsu execute-stage unit.
//   a, b   operands driven by the issuing stage
//   FUNC   3-bit operation select
//   r      registered result
//   z/n/c  registered zero / negative / carry-borrow-shiftout flags
// master: the stage that issues operations and consumes results.
// slave : the alsu itself.
interface alsu_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       FUNC;
  logic [WIDTH-1:0] r;
  logic             z;
  logic             n;
  logic             c;

  modport master (
    output a, b, FUNC,
    input  r, z, n, c
  );

  modport slave (
    input  a, b, FUNC,
    output r, z, n, c
  );
endinterface

// File: rtl/alsu.sv
// alsu: arithmetic/logic/shift unit with a one-cycle registered result.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset, clears r/z/n/c
//   bus    alsu_if slave: a, b, FUNC in; r, z, n, c out
// Every rising edge samples a, b, FUNC and loads the selected result with
// its flags. There is no handshake, so a new operation can issue each cycle.
module alsu #(
  parameter int WIDTH = 16
) (
  input  logic  clk,
  input  logic  rst_n,
  alsu_if.slave bus
);

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_SHL = 3'd2,
    OP_SHR = 3'd3,
    OP_AND = 3'd4,
    OP_XOR = 3'd5,
    OP_NOT = 3'd6,
    OP_INC = 3'd7
  } op_e;

  logic [WIDTH:0]   sumExt;
  logic [WIDTH:0]   diffExt;
  logic [WIDTH:0]   incExt;
  logic [WIDTH-1:0] resNext;
  logic             carryNext;
  logic [WIDTH-1:0] rQ;
  logic             zQ;
  logic             nQ;
  logic             cQ;
  op_e              op;

  assign op = op_e'(bus.FUNC);

  // Operands are zero-extended by one bit so the top bit of each result is
  // the unsigned carry out; for subtraction that bit is set exactly when
  // a < b, which is the borrow.
  assign sumExt  = {1'b0, bus.a} + {1'b0, bus.b};
  assign diffExt = {1'b0, bus.a} - {1'b0, bus.b};
  assign incExt  = {1'b0, bus.a} + {{WIDTH{1'b0}}, 1'b1};

  // Operation decode: pick the result word and the carry-type flag.
  always_comb begin
    resNext   = '0;
    carryNext = 1'b0;
    unique case (op)
      OP_ADD: begin
        resNext   = sumExt[WIDTH-1:0];
        carryNext = sumExt[WIDTH];
      end
      OP_SUB: begin
        resNext   = diffExt[WIDTH-1:0];
        carryNext = diffExt[WIDTH];
      end
      OP_SHL: begin
        resNext   = {bus.a[WIDTH-2:0], 1'b0};
        carryNext = bus.a[WIDTH-1];
      end
      OP_SHR: begin
        resNext   = {1'b0, bus.a[WIDTH-1:1]};
        carryNext = bus.a[0];
      end
      OP_AND: resNext = bus.a & bus.b;
      OP_XOR: resNext = bus.a ^ bus.b;
      OP_NOT: resNext = ~bus.a;
      OP_INC: begin
        resNext   = incExt[WIDTH-1:0];
        carryNext = incExt[WIDTH];
      end
      default: begin
        resNext   = '0;
        carryNext = 1'b0;
      end
    endcase
  end

  // Result and flag registers. z and n are derived from the same word that
  // is loaded into r, so the flags always describe the visible result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rQ <= '0;
      zQ <= 1'b0;
      nQ <= 1'b0;
      cQ <= 1'b0;
    end else begin
      rQ <= resNext;
      zQ <= (resNext == '0);
      nQ <= resNext[WIDTH-1];
      cQ <= carryNext;
    end
  end

  assign bus.r = rQ;
  assign bus.z = zQ;
  assign bus.n = nQ;
  assign bus.c = cQ;

endmodule

// File: tb/tb_alsu.sv
// tb_alsu: directed self-checking bench for alsu.
// Each scenario task drives hand-chosen operands and compares r/z/n/c
// against hand-computed values one cycle after the inputs are applied.
module tb_alsu;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  f;
    logic [15:0] r;
    logic        z;
    logic        n;
    logic        c;
  } vec_t;

  localparam logic [2:0] F_ADD = 3'd0;
  localparam logic [2:0] F_SUB = 3'd1;
  localparam logic [2:0] F_SHL = 3'd2;
  localparam logic [2:0] F_SHR = 3'd3;
  localparam logic [2:0] F_AND = 3'd4;
  localparam logic [2:0] F_XOR = 3'd5;
  localparam logic [2:0] F_NOT = 3'd6;
  localparam logic [2:0] F_INC = 3'd7;

  logic clk;
  logic rst_n;
  int   checks;
  int   passed;

  alsu_if #(.WIDTH(16)) bus ();

  alsu #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one operation on the falling edge, then step to just past the
  // rising edge that captures it.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                               input logic [2:0] f);
    @(negedge clk);
    bus.a    = a;
    bus.b    = b;
    bus.FUNC = f;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b1;
    bus.a    = 16'hFFFF;
    bus.b    = 16'h0001;
    bus.FUNC = F_SUB;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.r, bus.z, bus.n, bus.c} !== 19'h0)
      $display("[TB] FAIL reset_immediate got r=%h z=%b n=%b c=%b want all zero",
               bus.r, bus.z, bus.n, bus.c);
    else passed++;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.r, bus.z, bus.n, bus.c} !== 19'h0)
      $display("[TB] FAIL reset_held got r=%h z=%b n=%b c=%b want all zero",
               bus.r, bus.z, bus.n, bus.c);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_arith();
    vec_t tbl [0:1];
    tbl[0] = '{16'h0003, 16'h000A, F_ADD, 16'h000D, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{16'h0003, 16'h000A, F_SUB, 16'hFFF9, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 2; i++) begin
      applyStimulus(tbl[i].a, tbl[i].b, tbl[i].f);
      checks++;
      if ({bus.r, bus.z, bus.n, bus.c} !== {tbl[i].r, tbl[i].z, tbl[i].n, tbl[i].c})
        $display("[TB] FAIL arith[%0d] got r=%h z=%b n=%b c=%b want r=%h z=%b n=%b c=%b",
                 i, bus.r, bus.z, bus.n, bus.c, tbl[i].r, tbl[i].z, tbl[i].n, tbl[i].c);
      else passed++;
    end
  endtask

  task automatic test_shift();
    vec_t tbl [0:3];
    tbl[0] = '{16'h0003, 16'h0000, F_SHL, 16'h0006, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{16'h0003, 16'h0000, F_SHR, 16'h0001, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{16'h8001, 16'h0000, F_SHL, 16'h0002, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{16'h8000, 16'h5555, F_SHR, 16'h4000, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(tbl[i].a, tbl[i].b, tbl[i].f);
      checks++;
      if ({bus.r, bus.z, bus.n, bus.c} !== {tbl[i].r, tbl[i].z, tbl[i].n, tbl[i].c})
        $display("[TB] FAIL shift[%0d] got r=%h z=%b n=%b c=%b want r=%h z=%b n=%b c=%b",
                 i, bus.r, bus.z, bus.n, bus.c, tbl[i].r, tbl[i].z, tbl[i].n, tbl[i].c);
      else passed++;
    end
  endtask

  task automatic test_logic();
    vec_t tbl [0:3];
    tbl[0] = '{16'h0003, 16'h000A, F_AND, 16'h0002, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{16'h0003, 16'h000A, F_XOR, 16'h0009, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{16'h0003, 16'h000A, F_NOT, 16'hFFFC, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{16'h0003, 16'h000A, F_INC, 16'h0004, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(tbl[i].a, tbl[i].b, tbl[i].f);
      checks++;
      if ({bus.r, bus.z, bus.n, bus.c} !== {tbl[i].r, tbl[i].z, tbl[i].n, tbl[i].c})
        $display("[TB] FAIL logic[%0d] got r=%h z=%b n=%b c=%b want r=%h z=%b n=%b c=%b",
                 i, bus.r, bus.z, bus.n, bus.c, tbl[i].r, tbl[i].z, tbl[i].n, tbl[i].c);
      else passed++;
    end
  endtask

  task automatic test_boundary();
    vec_t tbl [0:6];
    tbl[0] = '{16'hFFFF, 16'h0001, F_ADD, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[1] = '{16'hFFFF, 16'h1234, F_INC, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{16'h0005, 16'h0005, F_SUB, 16'h0000, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{16'h0000, 16'h0001, F_SUB, 16'hFFFF, 1'b0, 1'b1, 1'b1};
    tbl[4] = '{16'h8000, 16'h8000, F_ADD, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{16'h7FFF, 16'h0001, F_ADD, 16'h8000, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{16'hFFFF, 16'h0000, F_NOT, 16'h0000, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      applyStimulus(tbl[i].a, tbl[i].b, tbl[i].f);
      checks++;
      if ({bus.r, bus.z, bus.n, bus.c} !== {tbl[i].r, tbl[i].z, tbl[i].n, tbl[i].c})
        $display("[TB] FAIL boundary[%0d] got r=%h z=%b n=%b c=%b want r=%h z=%b n=%b c=%b",
                 i, bus.r, bus.z, bus.n, bus.c, tbl[i].r, tbl[i].z, tbl[i].n, tbl[i].c);
      else passed++;
    end
  endtask

  // A new FUNC every cycle: just after driving, the output must still hold
  // the previous result; just after the edge it must hold the new one.
  task automatic test_back_to_back();
    vec_t tbl [0:7];
    tbl[0] = '{16'h1234, 16'h00FF, F_ADD, 16'h1333, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{16'h1234, 16'h00FF, F_SUB, 16'h1135, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{16'h1234, 16'h00FF, F_SHL, 16'h2468, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{16'h1234, 16'h00FF, F_SHR, 16'h091A, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{16'h1234, 16'h00FF, F_XOR, 16'h12CB, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{16'h1234, 16'h00FF, F_NOT, 16'hEDCB, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{16'h1234, 16'h00FF, F_INC, 16'h1235, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{16'h1234, 16'h00FF, F_AND, 16'h0034, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.a    = tbl[i].a;
      bus.b    = tbl[i].b;
      bus.FUNC = tbl[i].f;
      #1;
      if (i > 0) begin
        checks++;
        if ({bus.r, bus.z, bus.n, bus.c} !== {tbl[i-1].r, tbl[i-1].z, tbl[i-1].n, tbl[i-1].c})
          $display("[TB] FAIL b2b_hold[%0d] got r=%h z=%b n=%b c=%b want r=%h z=%b n=%b c=%b",
                   i, bus.r, bus.z, bus.n, bus.c,
                   tbl[i-1].r, tbl[i-1].z, tbl[i-1].n, tbl[i-1].c);
        else passed++;
      end
      @(posedge clk);
      #1;
      checks++;
      if ({bus.r, bus.z, bus.n, bus.c} !== {tbl[i].r, tbl[i].z, tbl[i].n, tbl[i].c})
        $display("[TB] FAIL b2b[%0d] got r=%h z=%b n=%b c=%b want r=%h z=%b n=%b c=%b",
                 i, bus.r, bus.z, bus.n, bus.c, tbl[i].r, tbl[i].z, tbl[i].n, tbl[i].c);
      else passed++;
    end
  endtask

  task automatic test_reset_midstream();
    applyStimulus(16'h0003, 16'h000A, F_SUB);
    checks++;
    if ({bus.r, bus.z, bus.n, bus.c} !== {16'hFFF9, 1'b0, 1'b1, 1'b1})
      $display("[TB] FAIL mid_pre got r=%h z=%b n=%b c=%b want r=fff9 z=0 n=1 c=1",
               bus.r, bus.z, bus.n, bus.c);
    else passed++;
    @(negedge clk);
    bus.FUNC = F_ADD;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.r, bus.z, bus.n, bus.c} !== 19'h0)
      $display("[TB] FAIL mid_async got r=%h z=%b n=%b c=%b want all zero",
               bus.r, bus.z, bus.n, bus.c);
    else passed++;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.r, bus.z, bus.n, bus.c} !== 19'h0)
      $display("[TB] FAIL mid_held got r=%h z=%b n=%b c=%b want all zero",
               bus.r, bus.z, bus.n, bus.c);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.r, bus.z, bus.n, bus.c} !== {16'h000D, 1'b0, 1'b0, 1'b0})
      $display("[TB] FAIL mid_release got r=%h z=%b n=%b c=%b want r=000d z=0 n=0 c=0",
               bus.r, bus.z, bus.n, bus.c);
    else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    test_reset();
    test_arith();
    test_shift();
    test_logic();
    test_boundary();
    test_back_to_back();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
